// File: rtl/panel_shift_out_if.sv
// Word handshake and serial panel signals between a word source and panel_shift_out.
// master drives the word side; slave is the serializer.
interface panel_shift_out_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D_IN;
  logic             D_VALID;
  logic             LATCH_EN;
  logic             D_READY;
  logic             SER_DATA;
  logic             SER_CLK;
  logic             SER_LATCH;
  logic             BUSY;
  logic             DONE;

  modport master (
    output D_IN, D_VALID, LATCH_EN,
    input  D_READY, SER_DATA, SER_CLK, SER_LATCH, BUSY, DONE
  );

  modport slave (
    input  D_IN, D_VALID, LATCH_EN,
    output D_READY, SER_DATA, SER_CLK, SER_LATCH, BUSY, DONE
  );
endinterface

// File: rtl/panel_shift_out.sv
// MSB-first serializer for the LED panel driver: data, divided shift clock and an
// optional latch strobe per word. All outputs come straight from flops.
module panel_shift_out #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RST,
  panel_shift_out_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_HIGH   = 3'd2,
    S_LATCH  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [DIV_W-1:0] div_q,       div_d;
  logic [BIT_W-1:0] bit_q,       bit_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic             latch_flag_q, latch_flag_d;
  logic             d_ready_q,   d_ready_d;
  logic             ser_data_q,  ser_data_d;
  logic             ser_clk_q,   ser_clk_d;
  logic             ser_latch_q, ser_latch_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Next-state and next-output computation for the whole transfer sequence.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    latch_flag_d = latch_flag_q;
    d_ready_d    = d_ready_q;
    ser_data_d   = ser_data_q;
    ser_clk_d    = ser_clk_q;
    ser_latch_d  = ser_latch_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        d_ready_d  = 1'b1;
        ser_clk_d  = 1'b0;
        ser_data_d = 1'b0;
        busy_d     = 1'b0;
        div_d      = DIV_ZERO;
        if (bus.D_VALID && d_ready_q) begin
          shreg_d      = bus.D_IN;
          latch_flag_d = bus.LATCH_EN;
          bit_d        = BIT_ZERO;
          ser_data_d   = bus.D_IN[WIDTH-1];
          d_ready_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d     = DIV_ZERO;
          ser_clk_d = 1'b1;
          state_d   = S_HIGH;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      // The panel samples on the rising edge, so data only moves when SER_CLK falls.
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d     = DIV_ZERO;
          ser_clk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            ser_data_d = 1'b0;
            if (latch_flag_q) begin
              ser_latch_d = 1'b1;
              state_d     = S_LATCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_FINISH;
            end
          end else begin
            shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
            ser_data_d = shreg_q[WIDTH-2];
            bit_d      = bit_q + BIT_ONE;
            state_d    = S_SETUP;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d       = DIV_ZERO;
          ser_latch_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_FINISH;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_FINISH: begin
        busy_d    = 1'b0;
        d_ready_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        div_d       = DIV_ZERO;
        bit_d       = BIT_ZERO;
        d_ready_d   = 1'b1;
        ser_data_d  = 1'b0;
        ser_clk_d   = 1'b0;
        ser_latch_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a latch pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      div_q        <= DIV_ZERO;
      bit_q        <= BIT_ZERO;
      shreg_q      <= {WIDTH{1'b0}};
      latch_flag_q <= 1'b0;
      d_ready_q    <= 1'b1;
      ser_data_q   <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_latch_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      latch_flag_q <= latch_flag_d;
      d_ready_q    <= d_ready_d;
      ser_data_q   <= ser_data_d;
      ser_clk_q    <= ser_clk_d;
      ser_latch_q  <= ser_latch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.D_READY   = d_ready_q;
  assign bus.SER_DATA  = ser_data_q;
  assign bus.SER_CLK   = ser_clk_q;
  assign bus.SER_LATCH = ser_latch_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_panel_shift_out.sv
// Directed bench for panel_shift_out: one instance with CLK_DIV=2, one with CLK_DIV=1.
// A negedge monitor collects shifted bits, edge counts and event timing per instance.
module tb_panel_shift_out;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  panel_shift_out_if #(.WIDTH(8)) bus_a ();
  panel_shift_out_if #(.WIDTH(8)) bus_b ();

  panel_shift_out #(.WIDTH(8), .CLK_DIV(2)) dut_a (.CLK(clk), .RST(rst_a), .bus(bus_a));
  panel_shift_out #(.WIDTH(8), .CLK_DIV(1)) dut_b (.CLK(clk), .RST(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  // Edge counter; cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  logic vld_w[2], rdy_w[2], rst_w[2], sclk_w[2], sdat_w[2], slat_w[2], done_w[2];
  assign vld_w[0] = bus_a.D_VALID;   assign vld_w[1] = bus_b.D_VALID;
  assign rdy_w[0] = bus_a.D_READY;   assign rdy_w[1] = bus_b.D_READY;
  assign rst_w[0] = rst_a;           assign rst_w[1] = rst_b;
  assign sclk_w[0] = bus_a.SER_CLK;  assign sclk_w[1] = bus_b.SER_CLK;
  assign sdat_w[0] = bus_a.SER_DATA; assign sdat_w[1] = bus_b.SER_DATA;
  assign slat_w[0] = bus_a.SER_LATCH; assign slat_w[1] = bus_b.SER_LATCH;
  assign done_w[0] = bus_a.DONE;     assign done_w[1] = bus_b.DONE;

  int          hs_edge[2]  = '{0, 0};
  int          hs_cnt[2]   = '{0, 0};
  int          rise_cnt[2] = '{0, 0};
  int          lat_cnt[2]  = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          lat_rel[2]  = '{-1, -1};
  int          done_rel[2] = '{-1, -1};
  int          rdy_rel[2]  = '{-1, -1};
  logic [63:0] bits[2]     = '{64'd0, 64'd0};
  logic        sclk_prev[2] = '{1'b0, 1'b0};
  logic        slat_prev[2] = '{1'b0, 1'b0};
  logic        rdy_prev[2]  = '{1'b1, 1'b1};

  // Observation only; relative times count edges after the handshake edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (vld_w[i] && rdy_w[i] && !rst_w[i]) begin
        hs_edge[i] <= cyc + 1;
        hs_cnt[i]  <= hs_cnt[i] + 1;
      end
      if (sclk_w[i] && !sclk_prev[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        bits[i]     <= {bits[i][62:0], sdat_w[i]};
      end
      if (slat_w[i]) lat_cnt[i] <= lat_cnt[i] + 1;
      if (slat_w[i] && !slat_prev[i]) lat_rel[i] <= cyc - hs_edge[i];
      if (done_w[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_rel[i] <= cyc - hs_edge[i];
      end
      if (rdy_w[i] && !rdy_prev[i]) rdy_rel[i] <= cyc - hs_edge[i];
      sclk_prev[i] <= sclk_w[i];
      slat_prev[i] <= slat_w[i];
      rdy_prev[i]  <= rdy_w[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int i, input int target, input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (done_cnt[i] >= target) break;
    end
    check(tag, 64'(done_cnt[i] >= target), 64'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] w, input logic le);
    @(posedge clk); #1;
    bus_a.D_IN = w; bus_a.LATCH_EN = le; bus_a.D_VALID = 1'b1;
    @(posedge clk); #1;
    bus_a.D_VALID = 1'b0;
  endtask

  int r0, l0, d0, h0;

  initial begin
    bus_a.D_IN = 8'h00; bus_a.D_VALID = 1'b0; bus_a.LATCH_EN = 1'b0;
    bus_b.D_IN = 8'h00; bus_b.D_VALID = 1'b0; bus_b.LATCH_EN = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk); #1;
    check("reset_a", {bus_a.D_READY, bus_a.SER_DATA, bus_a.SER_CLK, bus_a.SER_LATCH, bus_a.BUSY, bus_a.DONE}, 64'h20);
    check("reset_b", {bus_b.D_READY, bus_b.SER_DATA, bus_b.SER_CLK, bus_b.SER_LATCH, bus_b.BUSY, bus_b.DONE}, 64'h20);

    // Basic shift with latch.
    r0 = rise_cnt[0]; l0 = lat_cnt[0]; d0 = done_cnt[0];
    send_a(8'hA5, 1'b1);
    @(negedge clk); #1;
    check("a5_busy", {bus_a.BUSY, bus_a.D_READY}, 64'h2);
    wait_done(0, d0 + 1, "a5_done_seen");
    check("a5_bits", bits[0][7:0], 64'hA5);
    check("a5_rises", rise_cnt[0] - r0, 64'd8);
    check("a5_latch_len", lat_cnt[0] - l0, 64'd2);
    check("a5_latch_at", lat_rel[0], 64'd32);
    check("a5_done_cnt", done_cnt[0] - d0, 64'd1);
    check("a5_done_at", done_rel[0], 64'd34);
    check("a5_ready_at", rdy_rel[0], 64'd35);

    // No latch.
    r0 = rise_cnt[0]; l0 = lat_cnt[0]; d0 = done_cnt[0];
    send_a(8'hFF, 1'b0);
    wait_done(0, d0 + 1, "ff_done_seen");
    check("ff_bits", bits[0][7:0], 64'hFF);
    check("ff_rises", rise_cnt[0] - r0, 64'd8);
    check("ff_latch_len", lat_cnt[0] - l0, 64'd0);
    check("ff_done_at", done_rel[0], 64'd32);
    check("ff_ready_at", rdy_rel[0], 64'd33);

    // Word offered while busy must wait for D_READY.
    r0 = rise_cnt[0]; d0 = done_cnt[0]; h0 = hs_cnt[0];
    @(posedge clk); #1;
    bus_a.D_IN = 8'h3C; bus_a.LATCH_EN = 1'b0; bus_a.D_VALID = 1'b1;
    @(posedge clk); #1;
    bus_a.D_IN = 8'hC3;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (hs_cnt[0] >= h0 + 2) break;
    end
    check("busy_second_hs", 64'(hs_cnt[0] - h0), 64'd2);
    @(posedge clk); #1;
    bus_a.D_VALID = 1'b0;
    wait_done(0, d0 + 2, "busy_done_seen");
    check("busy_bits", bits[0][15:0], 64'h3CC3);
    check("busy_rises", rise_cnt[0] - r0, 64'd16);
    check("busy_hs_total", hs_cnt[0] - h0, 64'd2);

    // Reset after the third shift-clock rising edge.
    r0 = rise_cnt[0];
    send_a(8'h55, 1'b1);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (rise_cnt[0] >= r0 + 3) break;
    end
    check("rst_third_rise", rise_cnt[0] - r0, 64'd3);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk); #1;
    check("rst_outputs", {bus_a.D_READY, bus_a.SER_DATA, bus_a.SER_CLK, bus_a.SER_LATCH, bus_a.BUSY, bus_a.DONE}, 64'h20);
    l0 = lat_cnt[0]; d0 = done_cnt[0];
    repeat (40) @(negedge clk);
    #1;
    check("rst_no_latch", lat_cnt[0] - l0, 64'd0);
    check("rst_no_done", done_cnt[0] - d0, 64'd0);
    r0 = rise_cnt[0];
    send_a(8'h81, 1'b1);
    wait_done(0, d0 + 1, "r81_done_seen");
    check("r81_bits", bits[0][7:0], 64'h81);
    check("r81_rises", rise_cnt[0] - r0, 64'd8);
    check("r81_done_at", done_rel[0], 64'd34);

    // Reset and D_VALID at the same edge.
    r0 = rise_cnt[0]; h0 = hs_cnt[0];
    @(posedge clk); #1;
    rst_a = 1'b1; bus_a.D_IN = 8'hAA; bus_a.LATCH_EN = 1'b1; bus_a.D_VALID = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0; bus_a.D_VALID = 1'b0;
    @(negedge clk); #1;
    check("rstv_state", {bus_a.D_READY, bus_a.BUSY, bus_a.SER_CLK}, 64'h4);
    repeat (10) @(negedge clk);
    #1;
    check("rstv_no_rise", rise_cnt[0] - r0, 64'd0);
    check("rstv_no_hs", hs_cnt[0] - h0, 64'd0);
    check("rstv_idle", {bus_a.D_READY, bus_a.BUSY}, 64'h2);

    // CLK_DIV=1 corner.
    r0 = rise_cnt[1]; l0 = lat_cnt[1]; d0 = done_cnt[1];
    @(posedge clk); #1;
    bus_b.D_IN = 8'h01; bus_b.LATCH_EN = 1'b1; bus_b.D_VALID = 1'b1;
    @(posedge clk); #1;
    bus_b.D_VALID = 1'b0;
    wait_done(1, d0 + 1, "div1_done_seen");
    check("div1_bits", bits[1][7:0], 64'h01);
    check("div1_rises", rise_cnt[1] - r0, 64'd8);
    check("div1_latch_len", lat_cnt[1] - l0, 64'd1);
    check("div1_latch_at", lat_rel[1], 64'd16);
    check("div1_done_at", done_rel[1], 64'd17);
    check("div1_ready_at", rdy_rel[1], 64'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
